// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/result handshake bundle for the multi-cycle EX-stage ALU
interface alu_exec_unit_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               i_valid;
  logic               o_ready;
  logic [3:0]         i_ALU_CS;
  logic [DATA_W-1:0]  i_a;
  logic [DATA_W-1:0]  i_b;
  logic [SHAMT_W-1:0] i_shamt;
  logic               o_valid;
  logic               i_ready;
  logic [DATA_W-1:0]  o_result;
  logic               o_zero;
  logic               o_overflow;
  logic               o_err;

  modport slave (
    input  i_valid, i_ALU_CS, i_a, i_b, i_shamt, i_ready,
    output o_ready, o_valid, o_result, o_zero, o_overflow, o_err
  );

  modport master (
    output i_valid, i_ALU_CS, i_a, i_b, i_shamt, i_ready,
    input  o_ready, o_valid, o_result, o_zero, o_overflow, o_err
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle EX-stage ALU with iterative shifter and held, flagged result
// Optional feature: define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts through EXEC.
module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  alu_exec_unit_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam int         MSB    = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  state_t             state_q;
  logic [3:0]         op_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               ready_q;
  logic               valid_q;
  logic [DATA_W-1:0]  result_q;
  logic               zero_q;
  logic               ovf_q;
  logic               err_q;

  logic [DATA_W-1:0]  sum_d;
  logic [DATA_W-1:0]  diff_d;
  logic               ovf_add_d;
  logic               ovf_sub_d;
  logic [DATA_W-1:0]  exec_res_d;
  logic               exec_ovf_d;
  logic               exec_err_d;
  logic [DATA_W-1:0]  shift_d;
  logic               start_shift_d;

  always_comb begin
    sum_d      = a_q + b_q;
    diff_d     = a_q - b_q;
    ovf_add_d  = (a_q[MSB] == b_q[MSB]) && (sum_d[MSB] != a_q[MSB]);
    ovf_sub_d  = (a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
    exec_res_d = '0;
    exec_ovf_d = 1'b0;
    exec_err_d = 1'b0;
    case (op_q)
      OP_AND: exec_res_d = a_q & b_q;
      OP_OR:  exec_res_d = a_q | b_q;
      OP_NOR: exec_res_d = ~(a_q | b_q);
      OP_ADD: begin
        exec_res_d = sum_d;
        exec_ovf_d = ovf_add_d;
      end
      OP_SUB: begin
        exec_res_d = diff_d;
        exec_ovf_d = ovf_sub_d;
      end
      // Sign of the true difference: raw sign bit flipped when the subtraction overflowed.
      OP_SLT: exec_res_d = {{(DATA_W-1){1'b0}}, diff_d[MSB] ^ ovf_sub_d};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: exec_res_d = b_q << shamt_q;
      OP_SRL: exec_res_d = b_q >> shamt_q;
      OP_SRA: exec_res_d = $unsigned($signed(b_q) >>> shamt_q);
`else
      OP_SLL, OP_SRL, OP_SRA: exec_res_d = b_q;
`endif
      default: exec_err_d = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_d = {b_q[MSB-1:0], 1'b0};
      OP_SRL:  shift_d = {1'b0, b_q[MSB:1]};
      default: shift_d = {b_q[MSB], b_q[MSB:1]};
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign start_shift_d = 1'b0;
`else
  assign start_shift_d = (bus.i_ALU_CS == OP_SLL || bus.i_ALU_CS == OP_SRL ||
                          bus.i_ALU_CS == OP_SRA) && (bus.i_shamt != '0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shamt_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            op_q    <= bus.i_ALU_CS;
            a_q     <= bus.i_a;
            b_q     <= bus.i_b;
            shamt_q <= bus.i_shamt;
            ready_q <= 1'b0;
            state_q <= start_shift_d ? SHIFT : EXEC;
          end
        end
        EXEC: begin
          result_q <= exec_res_d;
          zero_q   <= (exec_res_d == '0);
          ovf_q    <= exec_ovf_d;
          err_q    <= exec_err_d;
          valid_q  <= 1'b1;
          state_q  <= DONE;
        end
        SHIFT: begin
          // b_q doubles as the working register; shamt_q counts the remaining steps.
          b_q     <= shift_d;
          shamt_q <= shamt_q - 1'b1;
          if (shamt_q == SHAMT_W'(1)) begin
            result_q <= shift_d;
            zero_q   <= (shift_d == '0);
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_result   = result_q;
  assign bus.o_zero     = zero_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_err      = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed vector bench for alu_exec_unit (honours ALU_BARREL_SHIFT_EN)
module tb_alu_exec_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op, input logic [4:0] shamt);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == 4'b1000 || op == 4'b1001 || op == 4'b1010) && shamt != 0) return int'(shamt);
    return 1;
`endif
  endfunction

  // Leaves the bench at the falling edge right after the accepting rising edge.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] shamt);
    int n;
    n = 0;
    while (bus.o_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL start_ready: o_ready stuck at %b, required 1", bus.o_ready);
    end
    bus.i_ALU_CS = op;
    bus.i_a      = a;
    bus.i_b      = b;
    bus.i_shamt  = shamt;
    bus.i_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid  = 1'b0;
    bus.i_a      = 32'hDEAD_BEEF;
    bus.i_b      = 32'h1234_5678;
    bus.i_shamt  = 5'd3;
    bus.i_ALU_CS = 4'b0001;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.o_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result(input string name);
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    check({name, " ready_after_take"}, 32'(bus.o_ready), 32'd1);
    check({name, " valid_after_take"}, 32'(bus.o_valid), 32'd0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    start_op(v.op, v.a, v.b, v.shamt);
    wait_valid(lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat(v.op, v.shamt)));
    check({name, " result"}, bus.o_result, v.res);
    check({name, " zero"}, 32'(bus.o_zero), 32'(v.zero));
    check({name, " overflow"}, 32'(bus.o_overflow), 32'(v.ovf));
    check({name, " err"}, 32'(bus.o_err), 32'(v.err));
    take_result(name);
  endtask

  initial begin
    int lat;
    errors = 0;
    checks = 0;

    vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0111, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b1010, 32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1001, 32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b1001, 32'h0,         32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0011, 32'h0000_0003, 32'h0000_0004, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0,  32'h0000_F000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'b0001, 32'h0000_0F0F, 32'h0000_F000, 5'd0,  32'h0000_FF0F, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b1000, 32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{4'b1010, 32'h0,         32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{4'b1111, 32'h0000_0001, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b1};

    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b0;
    bus.i_ALU_CS = 4'b0000;
    bus.i_a      = '0;
    bus.i_b      = '0;
    bus.i_shamt  = '0;
    rst = 1'b1;
    #2;
    check("reset o_ready", 32'(bus.o_ready), 32'd1);
    check("reset o_valid", 32'(bus.o_valid), 32'd0);
    check("reset o_result", bus.o_result, 32'd0);
    check("reset flags", {29'd0, bus.o_zero, bus.o_overflow, bus.o_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Hold the result in DONE while upstream inputs churn.
    start_op(4'b0010, 32'd3, 32'd4, 5'd0);
    wait_valid(lat);
    check("hold latency", 32'(lat), 32'd1);
    for (int c = 0; c < 5; c++) begin
      bus.i_valid  = c[0];
      bus.i_a      = $urandom;
      bus.i_ALU_CS = 4'b0110;
      @(negedge clk);
      check($sformatf("hold%0d result", c), bus.o_result, 32'd7);
      check($sformatf("hold%0d valid", c), 32'(bus.o_valid), 32'd1);
      check($sformatf("hold%0d ready", c), 32'(bus.o_ready), 32'd0);
    end
    bus.i_valid = 1'b0;
    take_result("hold");
    @(negedge clk);
    check("hold no_new_op", 32'(bus.o_valid), 32'd0);
    check("hold result_kept", bus.o_result, 32'd7);

    // Abort a long shift by reset partway through.
    start_op(4'b1000, 32'd0, 32'd1, 5'd20);
    repeat (6) @(negedge clk);
    check("abort pre valid", 32'(bus.o_valid), 32'd0);
    check("abort pre ready", 32'(bus.o_ready), 32'd0);
    check("abort pre result", bus.o_result, 32'd7);
    #1 rst = 1'b1;
    #1;
    check("abort rst result", bus.o_result, 32'd0);
    check("abort rst ready", 32'(bus.o_ready), 32'd1);
    check("abort rst valid", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec("after_abort", '{4'b1001, 32'h0, 32'hF000_0000, 5'd8, 32'h00F0_0000, 1'b0, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
